// File: rtl/hdb3_restore.sv
// HDB3 decoder back end: strips V/B substitutions from classified rail symbols,
// rebuilds NRZ data, flags line-code errors and tracks error count and lock.
module hdb3_restore #(
  parameter int unsigned ERR_CNT_W = 16,
  parameter int unsigned LOCK_N    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sym_en,
  input  logic [1:0]           in_v1,
  input  logic [1:0]           in_v2,
  input  logic                 err_clr,
  output logic                 data_out,
  output logic                 data_vld,
  output logic                 code_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 lock
);

  localparam int unsigned CLEAN_W = $clog2(LOCK_N + 1);
  localparam int unsigned ZRUN_W  = 3;

  typedef enum logic {ST_UNLOCK = 1'b0, ST_LOCK = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [3:0]           s_q, s_d;
  logic                 data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 cerr_q, cerr_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [ZRUN_W-1:0]    zrun_q, zrun_d;
  logic [CLEAN_W-1:0]   clean_q, clean_d;

  logic err_a_c, is_v_c, is_mark_c, is_space_c, err_b_c, err_c_c, err_any_c;

  // Symbol classification; illegal codes degrade to SPACE
  always_comb begin
    err_a_c    = (in_v1 == 2'b10) || (in_v2 == 2'b10) ||
                 ((in_v1 != 2'b00) && (in_v2 != 2'b00));
    is_v_c     = !err_a_c && ((in_v1 == 2'b11) || (in_v2 == 2'b11));
    is_mark_c  = !err_a_c && !is_v_c && ((in_v1 == 2'b01) || (in_v2 == 2'b01));
    is_space_c = !is_v_c && !is_mark_c;
    err_b_c    = is_v_c && (s_q[0] || s_q[1]);
    err_c_c    = is_space_c && (zrun_q >= ZRUN_W'(3));
    err_any_c  = err_a_c || err_b_c || err_c_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNLOCK;
      s_q     <= '0;
      data_q  <= 1'b0;
      vld_q   <= 1'b0;
      cerr_q  <= 1'b0;
      cnt_q   <= '0;
      zrun_q  <= '0;
      clean_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      cerr_q  <= cerr_d;
      cnt_q   <= cnt_d;
      zrun_q  <= zrun_d;
      clean_q <= clean_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    data_d  = data_q;
    vld_d   = sym_en;
    cerr_d  = 1'b0;
    cnt_d   = cnt_q;
    zrun_d  = zrun_q;
    clean_d = clean_q;

    if (sym_en) begin
      data_d = s_q[3];
      // A V retires itself, its two zeros and the B/0 it pairs with
      s_d    = is_v_c ? 4'b0000 : {s_q[2:0], is_mark_c};
      if (is_space_c) begin
        zrun_d = (zrun_q == '1) ? zrun_q : zrun_q + ZRUN_W'(1);
      end else begin
        zrun_d = '0;
      end
      cerr_d = err_any_c;
      if (err_any_c && (cnt_q != '1)) begin
        cnt_d = cnt_q + ERR_CNT_W'(1);
      end

      case (state_q)
        ST_UNLOCK: begin
          if (err_any_c) begin
            clean_d = '0;
          end else begin
            clean_d = clean_q + CLEAN_W'(1);
            if (clean_q == CLEAN_W'(LOCK_N - 1)) begin
              state_d = ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          if (err_any_c) begin
            clean_d = '0;
            state_d = ST_UNLOCK;
          end else if (clean_q < CLEAN_W'(LOCK_N)) begin
            clean_d = clean_q + CLEAN_W'(1);
          end
        end
        default: state_d = ST_UNLOCK;
      endcase
    end

    // Clear wins over a same-cycle increment
    if (err_clr) begin
      cnt_d = '0;
    end
  end

  assign data_out = data_q;
  assign data_vld = vld_q;
  assign code_err = cerr_q;
  assign err_cnt  = cnt_q;
  assign lock     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_hdb3_restore.sv
// Scoreboard bench for hdb3_restore: a symbol-history model predicts every
// strobe's outputs, queued at drive time and compared when data_vld appears.
module tb_hdb3_restore;

  localparam int unsigned ECW = 2;
  localparam int unsigned LN  = 8;
  localparam int CNT_MAX = (1 << ECW) - 1;

  localparam logic [1:0] SP = 2'b00;
  localparam logic [1:0] MK = 2'b01;
  localparam logic [1:0] VV = 2'b11;
  localparam logic [1:0] IL = 2'b10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           sym_en;
  logic [1:0]     in_v1, in_v2;
  logic           err_clr;
  logic           data_out, data_vld, code_err, lock;
  logic [ECW-1:0] err_cnt;

  hdb3_restore #(.ERR_CNT_W(ECW), .LOCK_N(LN)) dut (
    .clk(clk), .rst_n(rst_n), .sym_en(sym_en), .in_v1(in_v1), .in_v2(in_v2),
    .err_clr(err_clr), .data_out(data_out), .data_vld(data_vld),
    .code_err(code_err), .err_cnt(err_cnt), .lock(lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic d;
    logic ce;
    int   cnt;
    logic lk;
  } exp_t;

  exp_t q[$];
  bit   bits [0:4095];
  int   n, zrun, m_cnt, clean;
  bit   locked, last_d;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) bits[i] = 1'b0;
    n = 0; zrun = 0; m_cnt = 0; clean = 0; locked = 1'b0; last_d = 1'b0;
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sym_en = 1'b0; err_clr = 1'b0; in_v1 = SP; in_v2 = SP;
    #1;
    check("rst_data", int'(data_out), 0);
    check("rst_vld",  int'(data_vld), 0);
    check("rst_cerr", int'(code_err), 0);
    check("rst_cnt",  int'(err_cnt),  0);
    check("rst_lock", int'(lock),     0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [1:0] v1, input logic [1:0] v2,
                       input logic en, input logic clr);
    exp_t e;
    bit ea, isv, ism, iss, eb, ec, err;
    @(negedge clk);
    in_v1 = v1; in_v2 = v2; sym_en = en; err_clr = clr;
    e = '{d: 1'b0, ce: 1'b0, cnt: 0, lk: 1'b0};
    if (en) begin
      ea  = (v1 == IL) || (v2 == IL) || ((v1 != SP) && (v2 != SP));
      isv = !ea && ((v1 == VV) || (v2 == VV));
      ism = !ea && !isv && ((v1 == MK) || (v2 == MK));
      iss = !isv && !ism;
      eb  = isv && (((n >= 1) ? bits[n-1] : 1'b0) || ((n >= 2) ? bits[n-2] : 1'b0));
      ec  = iss && (zrun >= 3);
      err = ea || eb || ec;
      bits[n] = ism;
      if (isv) begin
        for (int k = 0; k < 4; k++) if (n - k >= 0) bits[n-k] = 1'b0;
      end
      e.d  = (n >= 4) ? bits[n-4] : 1'b0;
      zrun = iss ? zrun + 1 : 0;
      if (err && m_cnt < CNT_MAX) m_cnt++;
      if (err) begin
        locked = 1'b0; clean = 0;
      end else begin
        if (!locked && clean == LN - 1) locked = 1'b1;
        if (clean < LN) clean++;
      end
      n++;
      e.ce = err; e.lk = locked; last_d = e.d;
    end
    if (clr) m_cnt = 0;
    e.cnt = m_cnt;
    if (en) q.push_back(e);
    @(posedge clk); #1;
    check("vld", int'(data_vld), int'(en));
    if (data_vld && q.size() > 0) begin
      e = q.pop_front();
      check("data", int'(data_out), int'(e.d));
      check("cerr", int'(code_err), int'(e.ce));
      check("cnt",  int'(err_cnt),  e.cnt);
      check("lock", int'(lock),     int'(e.lk));
    end else begin
      check("idle_cerr", int'(code_err), 0);
      check("idle_data", int'(data_out), int'(last_d));
      check("idle_cnt",  int'(err_cnt),  m_cnt);
      check("idle_lock", int'(lock),     int'(locked));
    end
  endtask

  task automatic sym(input logic [1:0] v1, input logic [1:0] v2);
    drive(v1, v2, 1'b1, 1'b0);
  endtask

  task automatic marks(input int cnt);
    for (int i = 0; i < cnt; i++) sym(SP, MK);
  endtask

  task automatic sym_gap(input logic [1:0] v1, input logic [1:0] v2);
    drive(v1, v2, 1'b1, 1'b0);
    drive(SP, SP, 1'b0, 1'b0);
    drive(SP, SP, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; sym_en = 1'b0; err_clr = 1'b0; in_v1 = SP; in_v2 = SP;
    model_clear();

    // T1: plain data 1,0,1,1 then flush
    do_reset();
    sym(SP, MK); sym(SP, SP); sym(MK, SP); sym(SP, MK);
    marks(4);

    // T2: B00V after data 1
    do_reset();
    sym(SP, MK); sym(SP, MK); sym(SP, SP); sym(SP, SP); sym(SP, VV);
    marks(4);

    // T3: 000V after data 1,1, then V right after a mark
    do_reset();
    sym(MK, SP); sym(SP, MK); sym(SP, SP); sym(SP, SP); sym(SP, SP); sym(VV, SP);
    marks(5);
    sym(SP, VV);
    marks(4);

    // T4: zero-run errors, both rails marked, counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) sym(SP, SP);
    sym(MK, MK);
    sym(IL, SP);
    sym(VV, VV);
    marks(4);

    // T5: lock after LN clean symbols, illegal drops it, clear beats increment
    do_reset();
    marks(LN + 2);
    sym(IL, SP);
    marks(2);
    drive(SP, IL, 1'b1, 1'b1);
    drive(SP, SP, 1'b0, 1'b0);
    sym(MK, MK);
    drive(SP, SP, 1'b0, 1'b1);

    // T6: strobe gaps and reset in the middle of a V sequence
    do_reset();
    sym_gap(SP, MK); sym_gap(SP, MK); sym_gap(SP, SP);
    do_reset();
    for (int i = 0; i < 6; i++) sym_gap(MK, SP);
    sym_gap(SP, SP); sym_gap(SP, SP); sym_gap(SP, VV);
    for (int i = 0; i < 4; i++) sym_gap(SP, MK);

    // Random traffic with gaps, errors and clears
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      logic c;
      r = int'($urandom_range(0, 11));
      c = ($urandom_range(0, 19) == 0);
      case (r)
        0, 1:    drive(SP, MK, 1'b1, c);
        2, 3:    drive(MK, SP, 1'b1, c);
        4, 5, 6: drive(SP, SP, 1'b1, c);
        7:       drive(($urandom_range(0, 1) != 0) ? VV : SP,
                       ($urandom_range(0, 1) != 0) ? SP : VV, 1'b1, c);
        8:       drive(($urandom_range(0, 1) != 0) ? IL : MK, MK, 1'b1, c);
        default: drive(SP, SP, 1'b0, c);
      endcase
    end
    marks(LN + 1);

    check("q_left", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
